// File: rtl/mct_pkg.sv
// -----------------------------------------------------------------------------
// mct_pkg
// Shared definitions for the multi-channel toggler.
//   CNT_WIDTH_DEF : default width of the period and counter registers
//   period_t      : half-period type at the default width
//   period_fits() : checks that a reset half-period fits in a given width
// -----------------------------------------------------------------------------
package mct_pkg;

   localparam int CNT_WIDTH_DEF = 16;

   typedef logic [CNT_WIDTH_DEF-1:0] period_t;

   // True when 'period' can be held in an unsigned register of 'width' bits.
   function automatic bit period_fits(input int unsigned period, input int unsigned width);
      if (width >= 32) begin
         return 1'b1;
      end
      return period < (32'd1 << width);
   endfunction

endpackage : mct_pkg

// File: rtl/toggle_channel.sv
// -----------------------------------------------------------------------------
// toggle_channel
// One square-wave channel: counter, active half-period, shadow (pending)
// half-period and the toggle/flip output registers.
// Ports:
//   clk        in  rising-edge clock
//   rst        in  asynchronous active-low reset
//   clr        in  synchronous clear of counter and toggle
//   en         in  run enable for this channel
//   wr_stb     in  decoded period write strobe for this channel
//   wr_period  in  new half-period in clk cycles
//   toggle     out square-wave output
//   flip       out one-cycle strobe, high in the cycle toggle changes
// -----------------------------------------------------------------------------
module toggle_channel
   import mct_pkg::*;
#(
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
   parameter int DEFAULT_PERIOD = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 wr_stb,
   input  logic [CNT_WIDTH-1:0] wr_period,
   output logic                 toggle,
   output logic                 flip
);

   localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
   localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] active_q, active_d;
   logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
   logic                 pend_q, pend_d;
   logic                 tog_q, tog_d;
   logic                 flip_q, flip_d;
   logic                 stalled;

   assign stalled = (active_q == '0);

   always_comb begin
      // NOTE: every next-state signal gets a default before any branch, so no
      // path through this block leaves a signal unassigned and no latch is inferred.
      cnt_d    = cnt_q;
      active_d = active_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tog_d    = tog_q;
      flip_d   = 1'b0;

      if (clr) begin
         cnt_d = '0;
         tog_d = 1'b0;
         if (pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
         end
      end else if (en && stalled) begin
         cnt_d = '0;
      end else if (en) begin
         // active_q is non-zero here, so active_q - 1 cannot underflow and the
         // compare stays within CNT_WIDTH even for the all-ones period.
         if (cnt_q == active_q - ONE) begin
            cnt_d  = '0;
            tog_d  = ~tog_q;
            flip_d = 1'b1;
            if (pend_q) begin
               active_d = shadow_q;
               pend_d   = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end

      // The write is resolved after the count rules so that a write landing on
      // a wrap becomes the next pending value, and a write with clr wins over
      // the shadow load.
      if (wr_stb) begin
         if (clr || !en || stalled) begin
            active_d = wr_period;
            cnt_d    = '0;
            pend_d   = 1'b0;
         end else begin
            shadow_d = wr_period;
            pend_d   = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         active_q <= RST_PERIOD;
         shadow_q <= RST_PERIOD;
         pend_q   <= 1'b0;
         tog_q    <= 1'b0;
         flip_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         tog_q    <= tog_d;
         flip_q   <= flip_d;
      end
   end

   assign toggle = tog_q;
   assign flip   = flip_q;

endmodule : toggle_channel

// File: rtl/multi_channel_toggler.sv
// -----------------------------------------------------------------------------
// multi_channel_toggler
// NUM_CH independent square-wave channels with programmable half-periods.
// Ports:
//   clk        in  rising-edge clock
//   rst        in  asynchronous active-low reset
//   clr        in  synchronous clear of all channel counters and toggles
//   ch_en      in  per-channel run enable
//   wr_en      in  period write strobe
//   wr_ch      in  channel index for the write (out-of-range index is ignored)
//   wr_period  in  new half-period in clk cycles
//   toggle     out square-wave outputs
//   flip       out one-cycle strobes, high when the matching toggle changes
// -----------------------------------------------------------------------------
module multi_channel_toggler
   import mct_pkg::*;
#(
   parameter  int NUM_CH         = 4,
   parameter  int CNT_WIDTH      = CNT_WIDTH_DEF,
   parameter  int DEFAULT_PERIOD = 5,
   localparam int CH_IDX_W       = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic                 wr_en,
   input  logic [CH_IDX_W-1:0]  wr_ch,
   input  logic [CNT_WIDTH-1:0] wr_period,
   output logic [NUM_CH-1:0]    toggle,
   output logic [NUM_CH-1:0]    flip
);

   if (!period_fits(DEFAULT_PERIOD, CNT_WIDTH)) begin : g_bad_default
      $error("DEFAULT_PERIOD does not fit in CNT_WIDTH bits");
   end

   logic [NUM_CH-1:0] wr_stb;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // An index >= NUM_CH matches no channel, so such writes are dropped.
      assign wr_stb[i] = wr_en && (wr_ch == CH_IDX_W'(i));

      toggle_channel #(
         .CNT_WIDTH      (CNT_WIDTH),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .en        (ch_en[i]),
         .wr_stb    (wr_stb[i]),
         .wr_period (wr_period),
         .toggle    (toggle[i]),
         .flip      (flip[i])
      );
   end

endmodule : multi_channel_toggler

// File: tb/tb_multi_channel_toggler.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_toggler
// Drives directed and random stimulus on the falling edge, advances a
// behavioural model of every channel, and queues the expected registered
// outputs. A monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_multi_channel_toggler;

   localparam int NUM_CH    = 3;   // non power of two, so index 3 is out of range
   localparam int CNT_WIDTH = 4;   // small width so the all-ones period is reachable
   localparam int DEF_P     = 5;
   localparam int CH_IDX_W  = 2;
   localparam int MAX_P     = (1 << CNT_WIDTH) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clr;
   logic [NUM_CH-1:0]    ch_en;
   logic                 wr_en;
   logic [CH_IDX_W-1:0]  wr_ch;
   logic [CNT_WIDTH-1:0] wr_period;
   logic [NUM_CH-1:0]    toggle;
   logic [NUM_CH-1:0]    flip;

   always #5 clk = ~clk;

   multi_channel_toggler #(
      .NUM_CH         (NUM_CH),
      .CNT_WIDTH      (CNT_WIDTH),
      .DEFAULT_PERIOD (DEF_P)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .ch_en     (ch_en),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_period (wr_period),
      .toggle    (toggle),
      .flip      (flip)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: each channel counts enabled cycles since its last flip
   // and flips once that count reaches its half-period.
   // ---------------------------------------------------------------------------
   int m_elapsed [NUM_CH];
   int m_half    [NUM_CH];
   int m_next    [NUM_CH];
   bit m_has_next[NUM_CH];
   bit m_level   [NUM_CH];

   typedef struct {
      logic [NUM_CH-1:0] tog;
      logic [NUM_CH-1:0] flp;
   } exp_t;

   exp_t sb_q[$];

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_elapsed[i]  = 0;
         m_half[i]     = DEF_P;
         m_next[i]     = DEF_P;
         m_has_next[i] = 1'b0;
         m_level[i]    = 1'b0;
      end
   endfunction

   function automatic exp_t model_step(input bit c, input bit [NUM_CH-1:0] en,
                                       input bit we, input int ch, input int wp);
      exp_t e;
      e.tog = '0;
      e.flp = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bit hit;
         bit flipped;
         bit loads_now;
         hit       = we && (ch == i);
         flipped   = 1'b0;
         // A write takes effect at once unless the channel is actively counting.
         loads_now = c || !en[i] || (m_half[i] == 0);
         if (c) begin
            m_elapsed[i] = 0;
            m_level[i]   = 1'b0;
            if (m_has_next[i]) begin
               m_half[i]     = m_next[i];
               m_has_next[i] = 1'b0;
            end
         end else if (en[i]) begin
            if (m_half[i] == 0) begin
               m_elapsed[i] = 0;
            end else begin
               m_elapsed[i] = m_elapsed[i] + 1;
               if (m_elapsed[i] >= m_half[i]) begin
                  m_elapsed[i] = 0;
                  m_level[i]   = !m_level[i];
                  flipped      = 1'b1;
                  if (m_has_next[i]) begin
                     m_half[i]     = m_next[i];
                     m_has_next[i] = 1'b0;
                  end
               end
            end
         end
         if (hit) begin
            if (loads_now) begin
               m_half[i]     = wp;
               m_elapsed[i]  = 0;
               m_has_next[i] = 1'b0;
            end else begin
               m_next[i]     = wp;
               m_has_next[i] = 1'b1;
            end
         end
         e.tog[i] = m_level[i];
         e.flp[i] = flipped;
      end
      return e;
   endfunction

   // Apply inputs now (caller is at a falling edge) and queue the expected result.
   task automatic drive(input bit c, input bit [NUM_CH-1:0] en, input bit we,
                        input int ch, input int wp);
      clr       = c;
      ch_en     = en;
      wr_en     = we;
      wr_ch     = CH_IDX_W'(ch);
      wr_period = CNT_WIDTH'(wp);
      sb_q.push_back(model_step(c, en, we, ch, wp));
   endtask

   task automatic step(input bit c, input bit [NUM_CH-1:0] en, input bit we,
                       input int ch, input int wp);
      @(negedge clk);
      drive(c, en, we, ch, wp);
   endtask

   task automatic idle(input int n, input bit [NUM_CH-1:0] en);
      for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 0, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: outputs are registered, so one expected entry per rising edge.
   // ---------------------------------------------------------------------------
   exp_t mon_e;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("toggle", 32'(toggle), 32'(mon_e.tog));
            check("flip",   32'(flip),   32'(mon_e.flp));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, queue depth %0d", sb_q.size());
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   bit [NUM_CH-1:0] cur_en;

   initial begin
      rst       = 1'b0;
      clr       = 1'b0;
      ch_en     = '0;
      wr_en     = 1'b0;
      wr_ch     = '0;
      wr_period = '0;
      model_reset();

      // Reset held for two edges: outputs must stay low.
      repeat (2) @(posedge clk);
      #1;
      check("reset_toggle", 32'(toggle), 32'd0);
      check("reset_flip",   32'(flip),   32'd0);

      // Release with all channels enabled: first flip on the DEF_P-th edge.
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, '1, 1'b0, 0, 0);
      idle(2 * DEF_P + 2, '1);

      // Program periods while disabled, including the all-ones maximum.
      step(1'b0, '0, 1'b1, 0, 1);
      step(1'b0, '0, 1'b1, 1, 2);
      step(1'b0, '0, 1'b1, 2, MAX_P);
      idle(2 * MAX_P + 4, '1);

      // ch0 at period 8, retimed to 2 at cnt=3: current half-period completes.
      step(1'b0, 3'b110, 1'b1, 0, 8);
      idle(3, '1);
      step(1'b0, '1, 1'b1, 0, 2);
      idle(20, '1);

      // ch1 at period 6, frozen at cnt=2 for 10 cycles, then resumed.
      step(1'b0, 3'b101, 1'b1, 1, 6);
      idle(2, '1);
      idle(10, 3'b101);
      idle(10, '1);

      // Pending write on ch0 followed by a clear.
      step(1'b0, '1, 1'b1, 0, 3);
      idle(1, '1);
      step(1'b1, '1, 1'b0, 0, 0);
      idle(10, '1);
      // clr and write on the same cycle.
      step(1'b1, '1, 1'b1, 2, 4);
      idle(10, '1);

      // Stall ch1 with period 0, then an out-of-range write, then wake ch1.
      step(1'b0, '1, 1'b1, 1, 0);
      idle(5, '1);
      step(1'b0, '1, 1'b1, 3, 7);
      idle(6, '1);
      step(1'b0, '1, 1'b1, 1, 3);
      idle(8, '1);

      // Random traffic.
      cur_en = '1;
      for (int n = 0; n < 1500; n++) begin
         bit c;
         bit we;
         if ($urandom_range(0, 7) == 0) cur_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
         c  = ($urandom_range(0, 39) == 0);
         we = ($urandom_range(0, 3) == 0);
         step(c, cur_en, we, $urandom_range(0, 3), $urandom_range(0, MAX_P));
      end

      // Asynchronous reset between edges: outputs drop before the next edge.
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_toggle", 32'(toggle), 32'd0);
      check("async_rst_flip",   32'(flip),   32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, '1, 1'b0, 0, 0);
      idle(2 * DEF_P + 3, '1);

      // Let the monitor drain the queue, bounded by a few edges.
      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multi_channel_toggler
